// File: rtl/toggle_mon_pkg.sv
// Shared types and default widths for the toggle period monitor.
package toggle_mon_pkg;

  localparam int CW_DEF = 8;
  localparam int TW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/edge_detect.sv
// Registers the previous Q sample and flags rising/falling edges of Q_in.
module edge_detect (
  input  logic Clk,
  input  logic Q_in,
  output logic Rise_o,
  output logic Fall_o
);

  logic q_prev_q;

  // Captured unconditionally, reset cycles included, so the first
  // post-reset cycle never sees a stale previous value.
  always_ff @(posedge Clk) begin
    q_prev_q <= Q_in;
  end

  assign Rise_o = Q_in & ~q_prev_q;
  assign Fall_o = ~Q_in & q_prev_q;

endmodule

// File: rtl/toggle_period_monitor.sv
// Counts Q toggles and measures Clk cycles between Q rising edges,
// presenting each period through a single-entry valid/ready slot.
module toggle_period_monitor
  import toggle_mon_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          En,
  input  logic          Q_in,
  output logic [CW-1:0] Period,
  output logic          Period_valid,
  input  logic          Period_ready,
  output logic [TW-1:0] Toggle_count,
  output logic          Overflow,
  output logic          Dropped
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0] TC_MAX  = '1;

  logic          rise, fall;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          res_vld;
  logic [CW-1:0] per_q, per_d;
  logic          pv_q, pv_d;
  logic          drop_q, drop_d;
  logic [TW-1:0] tc_q, tc_d;

  edge_detect u_edge (
    .Clk    (Clk),
    .Q_in   (Q_in),
    .Rise_o (rise),
    .Fall_o (fall)
  );

  // Measurement FSM; cnt_q at a rise equals the posedges since the last rise.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (!En) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          state_q <= ARMED;
        end
        ARMED: begin
          if (rise) begin
            cnt_q   <= CW'(1);
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            cnt_q <= CW'(1);
          end else if (cnt_q == CNT_MAX) begin
            ovf_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ARMED;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign res_vld = En & rise & (state_q == MEASURE);

  // Consume first so a same-cycle completion can refill the slot.
  always_comb begin
    per_d  = per_q;
    pv_d   = pv_q;
    drop_d = 1'b0;
    if (pv_q && Period_ready) pv_d = 1'b0;
    if (res_vld) begin
      if (!pv_d) begin
        per_d = cnt_q;
        pv_d  = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_comb begin
    tc_d = tc_q;
    if ((rise | fall) && En && (tc_q != TC_MAX)) tc_d = tc_q + TW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      per_q  <= '0;
      pv_q   <= 1'b0;
      drop_q <= 1'b0;
      tc_q   <= '0;
    end else begin
      per_q  <= per_d;
      pv_q   <= pv_d;
      drop_q <= drop_d;
      tc_q   <= tc_d;
    end
  end

  assign Period       = per_q;
  assign Period_valid = pv_q;
  assign Toggle_count = tc_q;
  assign Overflow     = ovf_q;
  assign Dropped      = drop_q;

endmodule

// File: tb/tb_toggle_period_monitor.sv
// Drives a default-width and a narrow (CW=4, TW=4) monitor with identical
// stimulus and compares both against a timestamp-based reference model.
module tb_toggle_period_monitor;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic En = 1'b0;
  logic Q_in = 1'b0;
  logic Period_ready = 1'b0;

  logic [7:0]  per_a;
  logic        pv_a, ovf_a, drop_a;
  logic [15:0] tog_a;
  logic [3:0]  per_b;
  logic        pv_b, ovf_b, drop_b;
  logic [3:0]  tog_b;
  logic [26:0] obs_a;
  logic [10:0] obs_b;

  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  toggle_period_monitor #(.CW(8), .TW(16)) dut_a (
    .Clk(Clk), .Rst(Rst), .En(En), .Q_in(Q_in),
    .Period(per_a), .Period_valid(pv_a), .Period_ready(Period_ready),
    .Toggle_count(tog_a), .Overflow(ovf_a), .Dropped(drop_a)
  );

  toggle_period_monitor #(.CW(4), .TW(4)) dut_b (
    .Clk(Clk), .Rst(Rst), .En(En), .Q_in(Q_in),
    .Period(per_b), .Period_valid(pv_b), .Period_ready(Period_ready),
    .Toggle_count(tog_b), .Overflow(ovf_b), .Dropped(drop_b)
  );

  assign obs_a = {per_a, pv_a, tog_a, ovf_a, drop_a};
  assign obs_b = {per_b, pv_b, tog_b, ovf_b, drop_b};

  // Reference model: index 0 = dut_a, 1 = dut_b. Periods are differences
  // of posedge timestamps; mode 0 disabled, 1 waiting for a rise, 2 timing.
  int now = 0;
  bit m_qp = 1'b0;
  int maxp [2] = '{255, 15};
  int maxt [2] = '{65535, 15};
  int m_mode [2], m_trise [2], m_per [2], m_pv [2], m_tc [2], m_ovf [2], m_drop [2];

  function automatic logic [26:0] exp_a();
    return {8'(m_per[0]), 1'(m_pv[0]), 16'(m_tc[0]), 1'(m_ovf[0]), 1'(m_drop[0])};
  endfunction

  function automatic logic [10:0] exp_b();
    return {4'(m_per[1]), 1'(m_pv[1]), 4'(m_tc[1]), 1'(m_ovf[1]), 1'(m_drop[1])};
  endfunction

  task automatic step(input bit rst, input bit en, input bit q, input bit rdy);
    bit rise, edg;
    @(negedge Clk);
    Rst = rst; En = en; Q_in = q; Period_ready = rdy;
    @(posedge Clk);
    now++;
    rise = q && !m_qp;
    edg  = (q != m_qp);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mode[i] = 0; m_per[i] = 0; m_pv[i] = 0;
        m_tc[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
      end else begin
        bit rv;
        int res;
        rv = 1'b0;
        res = 0;
        if (edg && en && m_tc[i] < maxt[i]) m_tc[i]++;
        if (!en) m_mode[i] = 0;
        else if (m_mode[i] == 0) m_mode[i] = 1;
        else if (m_mode[i] == 1) begin
          if (rise) begin m_mode[i] = 2; m_trise[i] = now; end
        end else begin
          if (rise) begin
            rv = 1'b1; res = now - m_trise[i]; m_trise[i] = now;
          end else if (now - m_trise[i] == maxp[i]) begin
            m_ovf[i] = 1; m_mode[i] = 1;
          end
        end
        m_drop[i] = 0;
        if (m_pv[i] != 0 && rdy) m_pv[i] = 0;
        if (rv) begin
          if (m_pv[i] == 0) begin m_per[i] = res; m_pv[i] = 1; end
          else m_drop[i] = 1;
        end
      end
    end
    m_qp = q;
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, (k >= 2), 1, 0);
      total++;
      if (obs_a !== 27'd0) begin bad++; $display("FAIL reset_a k=%0d got=%h exp=0", k, obs_a); end
      total++;
      if (obs_b !== 11'd0) begin bad++; $display("FAIL reset_b k=%0d got=%h exp=0", k, obs_b); end
    end
  endtask

  task automatic test_const_toggle();
    int rises = 0;
    logic [15:0] prev_tog;
    for (int k = 0; k < 12; k++) begin
      bit q;
      q = k[0];
      prev_tog = tog_a;
      step(0, 1, q, 1);
      if (q) rises++;
      total++;
      if (obs_a !== exp_a()) begin bad++; $display("FAIL const_a k=%0d got=%h exp=%h", k, obs_a, exp_a()); end
      total++;
      if (obs_b !== exp_b()) begin bad++; $display("FAIL const_b k=%0d got=%h exp=%h", k, obs_b, exp_b()); end
      total++;
      if (tog_a !== prev_tog + 16'd1) begin bad++; $display("FAIL const_tog k=%0d got=%0d exp=%0d", k, tog_a, prev_tog + 16'd1); end
      if (q && rises >= 2) begin
        total++;
        if (!(pv_a === 1'b1 && per_a === 8'd2 && per_b === 4'd2))
          begin bad++; $display("FAIL const_period k=%0d got=%0d/%0d v=%b exp=2", k, per_a, per_b, pv_a); end
      end
    end
  endtask

  task automatic test_slow_input();
    for (int k = 0; k <= 60; k++) begin
      bit q, en;
      q  = (k % 10) < 5;
      en = !(k >= 40 && k < 45);
      step(0, en, q, 1);
      total++;
      if (obs_a !== exp_a()) begin bad++; $display("FAIL slow_a k=%0d got=%h exp=%h", k, obs_a, exp_a()); end
      total++;
      if (obs_b !== exp_b()) begin bad++; $display("FAIL slow_b k=%0d got=%h exp=%h", k, obs_b, exp_b()); end
      if (k == 20 || k == 30 || k == 60) begin
        total++;
        if (!(pv_a === 1'b1 && per_a === 8'd10))
          begin bad++; $display("FAIL slow_period k=%0d got=%0d v=%b exp=10", k, per_a, pv_a); end
      end else if (k >= 40) begin
        total++;
        if (pv_a !== 1'b0) begin bad++; $display("FAIL slow_idle k=%0d got=%b exp=0", k, pv_a); end
      end
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    for (int k = 0; k <= 18; k++) begin
      bit q, rdy;
      q   = ((k % 4 == 0) && k <= 12) || k == 18;
      rdy = (k == 18);
      step(0, 1, q, rdy);
      total++;
      if (obs_a !== exp_a()) begin bad++; $display("FAIL bp_a k=%0d got=%h exp=%h", k, obs_a, exp_a()); end
      total++;
      if (obs_b !== exp_b()) begin bad++; $display("FAIL bp_b k=%0d got=%h exp=%h", k, obs_b, exp_b()); end
      if (k >= 4 && k < 18) begin
        total++;
        if (!(pv_a === 1'b1 && per_a === 8'd4))
          begin bad++; $display("FAIL bp_hold k=%0d got=%0d v=%b exp=4", k, per_a, pv_a); end
      end
      if (k == 8 || k == 12 || k == 9) begin
        total++;
        if (drop_a !== (k != 9)) begin bad++; $display("FAIL bp_drop k=%0d got=%b exp=%b", k, drop_a, (k != 9)); end
      end
      if (k == 18) begin
        total++;
        if (!(pv_a === 1'b1 && per_a === 8'd6 && drop_a === 1'b0))
          begin bad++; $display("FAIL bp_refill got=%0d v=%b d=%b exp=6", per_a, pv_a, drop_a); end
      end
    end
  endtask

  task automatic test_overflow();
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    for (int k = 0; k <= 25; k++) begin
      bit q;
      q = (k == 0 || k == 22 || k == 25);
      step(0, 1, q, 1);
      total++;
      if (obs_a !== exp_a()) begin bad++; $display("FAIL ovf_a k=%0d got=%h exp=%h", k, obs_a, exp_a()); end
      total++;
      if (obs_b !== exp_b()) begin bad++; $display("FAIL ovf_b k=%0d got=%h exp=%h", k, obs_b, exp_b()); end
      if (k == 14 || k == 15 || k == 25) begin
        total++;
        if (ovf_b !== (k != 14)) begin bad++; $display("FAIL ovf_flag k=%0d got=%b exp=%b", k, ovf_b, (k != 14)); end
      end
    end
    total++;
    if (!(pv_b === 1'b1 && per_b === 4'd3 && ovf_a === 1'b0))
      begin bad++; $display("FAIL ovf_period got=%0d v=%b ovf_a=%b exp=3", per_b, pv_b, ovf_a); end
  endtask

  task automatic test_saturation();
    step(1, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      step(0, 1, ~k[0], 1);
      total++;
      if (obs_b !== exp_b()) begin bad++; $display("FAIL sat_b k=%0d got=%h exp=%h", k, obs_b, exp_b()); end
    end
    total++;
    if (!(tog_b === 4'd15 && tog_a === 16'd20))
      begin bad++; $display("FAIL sat_count got=%0d/%0d exp=15/20", tog_b, tog_a); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bit r, e, q, y;
      r = ($urandom_range(63) == 0);
      e = ($urandom_range(7) != 0);
      q = ($urandom_range(5) == 0) ? ~Q_in : Q_in;
      y = 1'($urandom_range(1));
      step(r, e, q, y);
      total++;
      if (obs_a !== exp_a()) begin bad++; $display("FAIL rand_a k=%0d got=%h exp=%h", k, obs_a, exp_a()); end
      total++;
      if (obs_b !== exp_b()) begin bad++; $display("FAIL rand_b k=%0d got=%h exp=%h", k, obs_b, exp_b()); end
    end
  endtask

  initial begin
    test_reset();
    test_const_toggle();
    test_slow_input();
    test_back_to_back();
    test_overflow();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
